// File: rtl/dac_wave_sequencer_if.sv
// Control and status bundle between a host and the DAC wave sequencer.
// The host drives the commands and FIFO samples; the sequencer reports the DAC code, tick and FIFO/error status.
interface dac_wave_sequencer_if #(
   parameter int DEPTH = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          ena;
   logic [7:0]    data_in;
   logic          wr_en;
   logic          load_div;
   logic [1:0]    mode;
   logic          start;
   logic          stop;
   logic          clear_flags;
   logic [7:0]    dac_code;
   logic          tick;
   logic          busy;
   logic [CW-1:0] fifo_count;
   logic          fifo_full;
   logic          fifo_empty;
   logic          overflow;
   logic          underrun;

   modport master (
      output ena, data_in, wr_en, load_div, mode, start, stop, clear_flags,
      input  dac_code, tick, busy, fifo_count, fifo_full, fifo_empty, overflow, underrun
   );

   modport slave (
      input  ena, data_in, wr_en, load_div, mode, start, stop, clear_flags,
      output dac_code, tick, busy, fifo_count, fifo_full, fifo_empty, overflow, underrun
   );
endinterface

// File: rtl/dac_wave_sequencer.sv
// R2R DAC code sequencer: direct, ramp, triangle or FIFO playback, one new code per divided tick.
// DEPTH must be a power of two, at least 2.
module dac_wave_sequencer #(
   parameter int         DEPTH     = 16,
   parameter logic [7:0] DIV_RESET = 8'd9
) (
   input logic                clk,
   input logic                rst_n,
   dac_wave_sequencer_if.slave bus
);
   localparam int                PW       = $clog2(DEPTH);
   localparam int                CW       = PW + 1;
   localparam logic [CW-1:0]     FULL_CNT = CW'(DEPTH);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
   typedef enum logic [1:0] {
      MODE_DIRECT = 2'b00,
      MODE_RAMP   = 2'b01,
      MODE_TRI    = 2'b10,
      MODE_FIFO   = 2'b11
   } mode_t;

   state_t        state, state_next;
   mode_t         mode;
   logic [7:0]    div_reg, div_cnt, dac_code, code_next;
   logic          dir_up, dir_next;
   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          overflow, underrun;
   logic          tick, fifo_full, fifo_empty, play, pop, push, ovf_ev, und_ev;
   logic          run_entry, idle_entry;

   assign mode = mode_t'(bus.mode);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      state_next = state;
      if (!bus.ena)                        state_next = IDLE;
      else if (bus.stop)                   state_next = IDLE;
      else if (bus.start && state == IDLE) state_next = RUN;
   end

   assign run_entry  = (state == IDLE) && (state_next == RUN);
   assign idle_entry = (state == RUN)  && (state_next == IDLE);

   assign tick       = (state == RUN) && (div_cnt == 8'd0);
   assign fifo_full  = (count == FULL_CNT);
   assign fifo_empty = (count == '0);

   // A pop frees a slot in the same edge, so a push into a full FIFO is only dropped without one.
   assign play   = tick && (mode == MODE_FIFO);
   assign pop    = play && !fifo_empty;
   assign und_ev = play && fifo_empty;
   assign push   = bus.wr_en && (!fifo_full || pop);
   assign ovf_ev = bus.wr_en && fifo_full && !pop;

   always_comb begin
      code_next = dac_code;
      dir_next  = dir_up;
      unique case (mode)
         MODE_DIRECT: code_next = bus.data_in;
         MODE_RAMP:   code_next = dac_code + 8'd1;
         MODE_TRI: begin
            if (dir_up) begin
               if (dac_code == 8'hFF) begin
                  code_next = 8'hFE;
                  dir_next  = 1'b0;
               end else begin
                  code_next = dac_code + 8'd1;
               end
            end else begin
               if (dac_code == 8'h00) begin
                  code_next = 8'h01;
                  dir_next  = 1'b1;
               end else begin
                  code_next = dac_code - 8'd1;
               end
            end
         end
         MODE_FIFO:   if (!fifo_empty) code_next = mem[rd_ptr];
         default:     code_next = dac_code;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_reg  <= DIV_RESET;
         div_cnt  <= 8'd0;
         dac_code <= 8'h00;
         dir_up   <= 1'b1;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         underrun <= 1'b0;
      end else begin
         if (bus.load_div) div_reg <= bus.data_in;

         // A divisor load restarts the phase immediately with the new value.
         if (bus.load_div)           div_cnt <= bus.data_in;
         else if (run_entry || tick) div_cnt <= div_reg;
         else if (state == RUN)      div_cnt <= div_cnt - 8'd1;

         if (tick) dac_code <= code_next;

         if (idle_entry) dir_up <= 1'b1;
         else if (tick)  dir_up <= dir_next;

         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         unique case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase

         // A new error event in the clearing cycle keeps the flag set.
         overflow <= ovf_ev || (overflow && !bus.clear_flags);
         underrun <= und_ev || (underrun && !bus.clear_flags);
      end
   end

   // NOTE: sample storage has no reset; reset empties the FIFO through the pointers and count alone.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.data_in;
   end

   assign bus.dac_code   = dac_code;
   assign bus.tick       = tick;
   assign bus.busy       = (state == RUN);
   assign bus.fifo_count = count;
   assign bus.fifo_full  = fifo_full;
   assign bus.fifo_empty = fifo_empty;
   assign bus.overflow   = overflow;
   assign bus.underrun   = underrun;
endmodule

// File: tb/tb_dac_wave_sequencer.sv
// Self-checking bench for dac_wave_sequencer: a vector table, directed corner sequences and
// randomized traffic, all compared each cycle against a queue-based reference model.
module tb_dac_wave_sequencer;
   localparam int         DEPTH     = 16;
   localparam logic [7:0] DIV_RESET = 8'd9;

   logic clk;
   logic rst_n;

   dac_wave_sequencer_if #(.DEPTH(DEPTH)) ifc ();

   dac_wave_sequencer #(.DEPTH(DEPTH), .DIV_RESET(DIV_RESET)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: phase counts RUN cycles since the last restart, the FIFO is a queue.
   bit         m_valid = 0;
   bit         m_run, m_up, m_ovf, m_und;
   int         m_div, m_phase, m_code;
   logic [7:0] m_q[$];

   typedef struct {
      logic [4:0] ctl;     // {ena, start, stop, load_div, wr_en}
      logic [1:0] mode;
      logic [7:0] data;
      logic [7:0] e_code;
      logic       e_tick;
      logic       e_busy;
      logic [7:0] e_count;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_tick();
      return m_run && (m_phase == m_div);
   endfunction

   function automatic logic [21:0] model_vec();
      int n = m_q.size();
      return {8'(m_code), m_tick(), m_run, 8'(n), (n == DEPTH), (n == 0), m_ovf, m_und};
   endfunction

   function automatic logic [21:0] dut_vec();
      return {ifc.dac_code, ifc.tick, ifc.busy, 8'(ifc.fifo_count), ifc.fifo_full,
              ifc.fifo_empty, ifc.overflow, ifc.underrun};
   endfunction

   task automatic model_update();
      bit t, next_run, ovf_ev, und_ev;
      if (!rst_n) begin
         m_run = 0; m_div = int'(DIV_RESET); m_phase = 0; m_code = 0; m_up = 1;
         m_ovf = 0; m_und = 0; m_q.delete(); m_valid = 1;
         return;
      end
      t = m_tick();
      ovf_ev = 0;
      und_ev = 0;
      if (t) begin
         case (ifc.mode)
            2'd0: m_code = int'(ifc.data_in);
            2'd1: m_code = (m_code + 1) % 256;
            2'd2: begin
               if (m_up && m_code == 255)     begin m_code = 254; m_up = 0; end
               else if (!m_up && m_code == 0) begin m_code = 1;   m_up = 1; end
               else m_code = m_up ? m_code + 1 : m_code - 1;
            end
            default: begin
               if (m_q.size() > 0) m_code = int'(m_q.pop_front());
               else und_ev = 1;
            end
         endcase
      end
      if (ifc.wr_en) begin
         if (m_q.size() < DEPTH) m_q.push_back(ifc.data_in);
         else ovf_ev = 1;
      end
      m_ovf = ovf_ev || (m_ovf && !ifc.clear_flags);
      m_und = und_ev || (m_und && !ifc.clear_flags);
      next_run = !ifc.ena ? 0 : ifc.stop ? 0 : (ifc.start ? 1 : m_run);
      if (ifc.load_div) begin
         m_div = int'(ifc.data_in);
         m_phase = 0;
      end else if ((!m_run && next_run) || t) m_phase = 0;
      else if (m_run) m_phase++;
      if (m_run && !next_run) m_up = 1;
      m_run = next_run;
   endtask

   // One clock: compare against the model mid-cycle, advance the model, land #1 past the edge.
   task automatic step();
      @(negedge clk);
      if (m_valid) check("model", 32'(dut_vec()), 32'(model_vec()));
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      ifc.ena = 1; ifc.start = 0; ifc.stop = 0; ifc.load_div = 0;
      ifc.wr_en = 0; ifc.clear_flags = 0; ifc.mode = 2'd0; ifc.data_in = 8'h00;
   endtask

   task automatic do_reset();
      rst_n = 0;
      step();
      rst_n = 1;
   endtask

   task automatic wait_tick();
      int n = 0;
      while (ifc.tick !== 1'b1 && n < 300) begin
         step();
         n++;
      end
      check("tick_seen", ifc.tick, 1);
   endtask

   function automatic int tri_val(input int k);
      int p = k % 510;
      return (p <= 255) ? p : 510 - p;
   endfunction

   initial begin
      vecs[0]  = '{5'b10001, 2'd0, 8'h11, 8'h00, 1'b0, 1'b0, 8'd1};
      vecs[1]  = '{5'b10001, 2'd0, 8'h22, 8'h00, 1'b0, 1'b0, 8'd2};
      vecs[2]  = '{5'b10010, 2'd0, 8'h01, 8'h00, 1'b0, 1'b0, 8'd2};
      vecs[3]  = '{5'b11000, 2'd3, 8'h00, 8'h00, 1'b0, 1'b1, 8'd2};
      vecs[4]  = '{5'b10000, 2'd3, 8'h00, 8'h00, 1'b1, 1'b1, 8'd2};
      vecs[5]  = '{5'b10000, 2'd3, 8'h00, 8'h11, 1'b0, 1'b1, 8'd1};
      vecs[6]  = '{5'b10000, 2'd3, 8'h00, 8'h11, 1'b1, 1'b1, 8'd1};
      vecs[7]  = '{5'b11100, 2'd3, 8'h00, 8'h22, 1'b0, 1'b0, 8'd0};
      vecs[8]  = '{5'b11100, 2'd0, 8'h00, 8'h22, 1'b0, 1'b0, 8'd0};
      vecs[9]  = '{5'b01000, 2'd0, 8'h00, 8'h22, 1'b0, 1'b0, 8'd0};
      vecs[10] = '{5'b11000, 2'd1, 8'h00, 8'h22, 1'b0, 1'b1, 8'd0};
      vecs[11] = '{5'b10000, 2'd1, 8'h00, 8'h22, 1'b1, 1'b1, 8'd0};
      vecs[12] = '{5'b00000, 2'd1, 8'h00, 8'h23, 1'b0, 1'b0, 8'd0};
      vecs[13] = '{5'b10000, 2'd1, 8'h00, 8'h23, 1'b0, 1'b0, 8'd0};

      drive_idle();
      rst_n = 0;
      #1;
      do_reset();
      check("rst_code", ifc.dac_code, 8'h00);
      check("rst_tick", ifc.tick, 0);
      check("rst_busy", ifc.busy, 0);
      check("rst_empty", ifc.fifo_empty, 1);
      check("rst_full", ifc.fifo_full, 0);
      check("rst_count", ifc.fifo_count, 0);
      check("rst_flags", {ifc.overflow, ifc.underrun}, 0);

      // Vector table: push, playback, start/stop race, ena drop with code held.
      for (int i = 0; i < 14; i++) begin
         {ifc.ena, ifc.start, ifc.stop, ifc.load_div, ifc.wr_en} = vecs[i].ctl;
         ifc.mode    = vecs[i].mode;
         ifc.data_in = vecs[i].data;
         step();
         check($sformatf("vec%0d_code", i), ifc.dac_code, vecs[i].e_code);
         check($sformatf("vec%0d_tick", i), ifc.tick, vecs[i].e_tick);
         check($sformatf("vec%0d_busy", i), ifc.busy, vecs[i].e_busy);
         check($sformatf("vec%0d_count", i), ifc.fifo_count, vecs[i].e_count);
      end

      // Ramp with div_reg=3: ticks at cycles 4, 8, 12; codes 1, 2, 3 from 5, 9, 13.
      drive_idle();
      do_reset();
      ifc.load_div = 1; ifc.data_in = 8'd3;
      step();
      ifc.load_div = 0; ifc.data_in = 8'd0; ifc.mode = 2'd1; ifc.start = 1;
      step();
      ifc.start = 0;
      for (int c = 1; c <= 13; c++) begin
         check($sformatf("ramp_tick_c%0d", c), ifc.tick, (c % 4 == 0));
         check($sformatf("ramp_code_c%0d", c), ifc.dac_code, (c - 1) / 4);
         step();
      end
      ifc.load_div = 1; ifc.data_in = 8'd0;
      step();
      ifc.load_div = 0;
      for (int c = 0; c < 3; c++) begin
         check("div0_tick", ifc.tick, 1);
         step();
      end
      ifc.ena = 0;
      step();
      check("ena_low_busy", ifc.busy, 0);
      check("ena_low_tick", ifc.tick, 0);
      check("ena_low_code", ifc.dac_code, 8'd7);
      step();
      check("ena_low_hold", ifc.dac_code, 8'd7);

      // Ramp wrap 255 -> 0 with a tick every cycle.
      drive_idle();
      ifc.load_div = 1; ifc.data_in = 8'd0;
      step();
      ifc.load_div = 0; ifc.data_in = 8'hFF; ifc.start = 1;
      step();
      ifc.start = 0;
      step();
      check("wrap_pre", ifc.dac_code, 8'hFF);
      ifc.mode = 2'd1;
      step();
      check("wrap_post", ifc.dac_code, 8'h00);
      ifc.stop = 1;
      step();

      // Triangle with div_reg=0: 1..255, 254..0, then 1 again.
      drive_idle();
      do_reset();
      ifc.load_div = 1; ifc.data_in = 8'd0;
      step();
      ifc.load_div = 0; ifc.mode = 2'd2; ifc.start = 1;
      step();
      ifc.start = 0;
      for (int k = 1; k <= 520; k++) begin
         step();
         check($sformatf("tri_k%0d", k), ifc.dac_code, tri_val(k));
      end

      // FIFO playback: three samples, then an underrunning fourth tick, then clear.
      drive_idle();
      do_reset();
      ifc.wr_en = 1;
      foreach (vecs[i]) if (i < 3) begin
         ifc.data_in = 8'(8'h11 * (i + 1));
         step();
      end
      ifc.wr_en = 0; ifc.load_div = 1; ifc.data_in = 8'd1;
      step();
      ifc.load_div = 0; ifc.mode = 2'd3; ifc.start = 1;
      step();
      ifc.start = 0;
      for (int i = 0; i < 4; i++) begin
         wait_tick();
         step();
         check($sformatf("play_code%0d", i), ifc.dac_code, (i < 3) ? 8'(8'h11 * (i + 1)) : 8'h33);
         check($sformatf("play_und%0d", i), ifc.underrun, (i == 3));
      end
      ifc.stop = 1;
      step();
      ifc.stop = 0; ifc.clear_flags = 1;
      step();
      ifc.clear_flags = 0;
      check("und_cleared", ifc.underrun, 0);

      // Overflow, then a push and pop in the same cycle on a full FIFO.
      drive_idle();
      do_reset();
      ifc.wr_en = 1;
      for (int i = 1; i <= DEPTH + 1; i++) begin
         ifc.data_in = 8'(i);
         step();
      end
      check("ovf_full", ifc.fifo_full, 1);
      check("ovf_count", ifc.fifo_count, DEPTH);
      check("ovf_flag", ifc.overflow, 1);
      ifc.wr_en = 0; ifc.load_div = 1; ifc.data_in = 8'd0;
      step();
      ifc.load_div = 0; ifc.mode = 2'd3; ifc.start = 1;
      step();
      ifc.start = 0; ifc.wr_en = 1; ifc.data_in = 8'hAA;
      step();
      ifc.wr_en = 0;
      check("pushpop_count", ifc.fifo_count, DEPTH);
      check("pushpop_code", ifc.dac_code, 8'd1);
      check("pushpop_ovf", ifc.overflow, 1);
      for (int k = 2; k <= DEPTH; k++) begin
         step();
         check($sformatf("order_%0d", k), ifc.dac_code, k);
      end
      step();
      check("order_last", ifc.dac_code, 8'hAA);
      check("order_empty", ifc.fifo_empty, 1);
      ifc.stop = 1;
      step();

      // Reset mid-RUN with five samples queued.
      drive_idle();
      do_reset();
      ifc.wr_en = 1;
      for (int i = 0; i < 5; i++) begin
         ifc.data_in = 8'(8'h40 + i);
         step();
      end
      ifc.wr_en = 0; ifc.load_div = 1; ifc.data_in = 8'd2;
      step();
      ifc.load_div = 0; ifc.data_in = 8'h5A; ifc.start = 1;
      step();
      ifc.start = 0;
      wait_tick();
      step();
      check("midrun_code", ifc.dac_code, 8'h5A);
      check("midrun_count", ifc.fifo_count, 5);
      rst_n = 0;
      step();
      rst_n = 1;
      check("rstrun_code", ifc.dac_code, 8'h00);
      check("rstrun_count", ifc.fifo_count, 0);
      check("rstrun_busy", ifc.busy, 0);
      check("rstrun_flags", {ifc.overflow, ifc.underrun}, 0);
      check("rstrun_empty", ifc.fifo_empty, 1);

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         rst_n           = ($urandom_range(0, 199) != 0);
         ifc.ena         = ($urandom_range(0, 19) != 0);
         ifc.start       = ($urandom_range(0, 9) == 0);
         ifc.stop        = ($urandom_range(0, 19) == 0);
         ifc.load_div    = ($urandom_range(0, 19) == 0);
         ifc.wr_en       = ($urandom_range(0, 4) < 2);
         ifc.clear_flags = ($urandom_range(0, 19) == 0);
         ifc.mode        = 2'($urandom_range(0, 3));
         ifc.data_in     = ifc.load_div ? 8'($urandom_range(0, 4)) : 8'($urandom);
         step();
      end
      rst_n = 1;
      drive_idle();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/dac_wave_sequencer.md
DAC_WAVE_SEQUENCER -- requirements
Module: dac_wave_sequencer

Interface
REQ-001 Parameters: DEPTH, default 16, FIFO sample entries (power of 2); DIV_RESET, default 9, reset value of the tick divisor.
REQ-002 clk  input  1  single clock for the block; expected 10 MHz.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 ena  input  1  design enable; low forces IDLE.
REQ-005 data_in  input  8  sample, direct code or divisor value.
REQ-006 wr_en  input  1  push data_in into the FIFO.
REQ-007 load_div  input  1  load data_in into the divisor register.
REQ-008 mode  input  2  00 direct, 01 ramp, 10 triangle, 11 FIFO playback.
REQ-009 start / stop  input  1 each  enter RUN / enter IDLE.
REQ-010 clear_flags  input  1  clear the overflow and underrun flags.
REQ-011 dac_code  output  8  registered code driven to the R2R DAC control.
REQ-012 tick  output  1  one-cycle sample strobe.
REQ-013 busy  output  1  high in RUN.
REQ-014 fifo_count  output  log2(DEPTH)+1  occupancy; fifo_full / fifo_empty  output  1 each.
REQ-015 overflow / underrun  output  1 each  sticky error flags.

Function
REQ-016 FSM states: IDLE and RUN. Transitions are evaluated each clock edge in this order:
- !ena -> IDLE
- stop -> IDLE (stop wins over a simultaneous start)
- start in IDLE -> RUN
REQ-017 Divisor register div_reg: load_div loads it with data_in on any cycle, in either state.
REQ-018 Divider counter div_cnt (8 bit):
- Loaded with div_reg on entry to RUN, on every tick, and on every load_div (new value takes effect at once and restarts the phase).
- Otherwise decrements each cycle in RUN.
REQ-019 tick = RUN && div_cnt==0 (combinational from registers). Sample period = div_reg+1 cycles; div_reg=0 gives a tick every cycle.
REQ-020 dac_code changes only on the clock edge ending a tick cycle. The new value is visible the following cycle. mode is sampled in the tick cycle.
REQ-021 Mode 00 (direct): dac_code <= data_in.
REQ-022 Mode 01 (ramp): dac_code <= dac_code+1, modulo 256 (255 -> 0).
REQ-023 Mode 10 (triangle): dir register, up=1.
- Up: dac_code increments; at 255 the next value is 254 and dir flips to down.
- Down: dac_code decrements; at 0 the next value is 1 and dir flips to up.
- dir is set to up on reset and on IDLE entry.
REQ-024 Mode 11 (FIFO playback):
- Not empty: pop the head into dac_code.
- Empty: dac_code holds its value and underrun sets.
REQ-025 Mode change during RUN: the next value is computed from the current dac_code; there is no jump.
REQ-026 FIFO: circular buffer of DEPTH entries. A push (wr_en) is accepted in any state when not full. A push while full is dropped and sets overflow.
REQ-027 Simultaneous push and pop: both occur and count is unchanged, including when the FIFO is full. If the FIFO is empty, the pop underruns and the push is accepted (count becomes 1).
REQ-028 Pointers wrap modulo DEPTH. fifo_count ranges 0..DEPTH. fifo_full = (count==DEPTH); fifo_empty = (count==0).
REQ-029 Sticky flags:
- overflow and underrun stay set until clear_flags or reset.
- If clear_flags coincides with a new error event, the flag remains set.
REQ-030 In IDLE: dac_code holds its last value, tick=0, busy=0, and the FIFO remains writable.

Reset
REQ-031 rst_n low at a clock edge sets:
- state=IDLE, div_reg=DIV_RESET, div_cnt=0, dac_code=0x00, dir=up
- FIFO pointers and count = 0, overflow=0, underrun=0
REQ-032 After that reset edge, outputs are tick=0, busy=0, fifo_empty=1, fifo_full=0.
REQ-033 Reset asserted mid-RUN or mid-FIFO-activity discards all FIFO contents. No output changes before the next clock edge.

Verification
REQ-034 Ramp: div_reg=3, mode=01, start at cycle 0 -> ticks at cycles 4, 8, 12; dac_code = 1, 2, 3 from cycles 5, 9, 13; 255 wraps to 0.
REQ-035 Triangle: div_reg=0, mode=10 -> dac_code 1..255 then 254..0 then 1; period 510 ticks.
REQ-036 FIFO playback: push 0x11, 0x22, 0x33; div_reg=1; mode=11; run -> dac_code 0x11, 0x22, 0x33 on successive ticks. The 4th tick holds 0x33 and sets underrun; clear_flags clears it.
REQ-037 Overflow: push DEPTH+1 samples in IDLE -> fifo_full=1, count=DEPTH, overflow=1. Then push+pop in the same cycle -> count stays DEPTH and FIFO order is preserved.
REQ-038 Control races:
- start+stop in the same cycle -> remains IDLE.
- load_div=0 mid-RUN -> tick every cycle from the next cycle.
- ena low -> IDLE with dac_code held.
REQ-039 Reset mid-RUN with 5 samples queued -> next cycle: dac_code=0, count=0, busy=0, flags=0.
